axi_slave_arb2: RTL and testbench

AXI_SLAVE_ARB2 -- requirements
Module: axi_slave_arb2

---
 rtl/axi_slave_arb2_pkg.sv | 14 +
 rtl/axi_slave_arb2_rr.sv | 15 +
 rtl/axi_slave_arb2.sv | 255 +++++++++++++++++++++++++
 tb/tb_axi_slave_arb2.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_arb2_pkg.sv
// Shared types and default widths for the two-master AXI slave arbiter.
package axi_slave_arb2_pkg;
    localparam int DEF_ADDR_W = 40;
    localparam int DEF_DATA_W = 128;
    localparam int DEF_ID_W   = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR_A = 3'd2,
        WR_D = 3'd3,
        WR_B = 3'd4
    } arb_state_t;
endpackage

// File: rtl/axi_slave_arb2_rr.sv
// Two-way round-robin picker; a tie goes to the master not granted last.
module axi_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       en,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) gnt = last_gnt ? 2'b01 : 2'b10;
            else              gnt = req;
        end
    end
endmodule

// File: rtl/axi_slave_arb2.sv
// Arbitrates two AXI masters onto one single-outstanding slave, one whole
// transaction at a time, with combinational pass-through on the owned channel.
module axi_slave_arb2
    import axi_slave_arb2_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ID_W   = DEF_ID_W
) (
    input  logic                pll_core_cpuclk,
    input  logic                pad_cpu_rst_b,
    // master 0
    input  logic                m0_awvalid,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic [ID_W-1:0]     m0_awid,
    input  logic [7:0]          m0_awlen,
    input  logic [2:0]          m0_awsize,
    input  logic [1:0]          m0_awburst,
    input  logic [2:0]          m0_awprot,
    input  logic [3:0]          m0_awcache,
    output logic                m0_awready,
    input  logic                m0_wvalid,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wlast,
    input  logic [ID_W-1:0]     m0_wid,
    output logic                m0_wready,
    output logic                m0_bvalid,
    output logic [ID_W-1:0]     m0_bid,
    output logic [1:0]          m0_bresp,
    input  logic                m0_bready,
    input  logic                m0_arvalid,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [ID_W-1:0]     m0_arid,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic [1:0]          m0_arburst,
    input  logic [2:0]          m0_arprot,
    input  logic [3:0]          m0_arcache,
    output logic                m0_arready,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [ID_W-1:0]     m0_rid,
    output logic [1:0]          m0_rresp,
    output logic                m0_rlast,
    input  logic                m0_rready,
    // master 1
    input  logic                m1_awvalid,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [ID_W-1:0]     m1_awid,
    input  logic [7:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic [1:0]          m1_awburst,
    input  logic [2:0]          m1_awprot,
    input  logic [3:0]          m1_awcache,
    output logic                m1_awready,
    input  logic                m1_wvalid,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    input  logic [ID_W-1:0]     m1_wid,
    output logic                m1_wready,
    output logic                m1_bvalid,
    output logic [ID_W-1:0]     m1_bid,
    output logic [1:0]          m1_bresp,
    input  logic                m1_bready,
    input  logic                m1_arvalid,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [ID_W-1:0]     m1_arid,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic [1:0]          m1_arburst,
    input  logic [2:0]          m1_arprot,
    input  logic [3:0]          m1_arcache,
    output logic                m1_arready,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [ID_W-1:0]     m1_rid,
    output logic [1:0]          m1_rresp,
    output logic                m1_rlast,
    input  logic                m1_rready,
    // slave
    output logic                s_awvalid,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [ID_W-1:0]     s_awid,
    output logic [7:0]          s_awlen,
    output logic [2:0]          s_awsize,
    output logic [1:0]          s_awburst,
    output logic [2:0]          s_awprot,
    output logic [3:0]          s_awcache,
    input  logic                s_awready,
    output logic                s_wvalid,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    output logic [ID_W-1:0]     s_wid,
    input  logic                s_wready,
    input  logic                s_bvalid,
    input  logic [ID_W-1:0]     s_bid,
    input  logic [1:0]          s_bresp,
    output logic                s_bready,
    output logic                s_arvalid,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [ID_W-1:0]     s_arid,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    output logic [2:0]          s_arprot,
    output logic [3:0]          s_arcache,
    input  logic                s_arready,
    input  logic                s_rvalid,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [ID_W-1:0]     s_rid,
    input  logic [1:0]          s_rresp,
    input  logic                s_rlast,
    output logic                s_rready
);
    localparam int STRB_W = DATA_W / 8;

    arb_state_t state;
    logic       owner, last_gnt, ar_done;
    logic [1:0] gnt;

    logic [1:0]                 awv, arv, wv, wl, bready_m, rready_m;
    logic [1:0][ADDR_W-1:0]     awaddr_m, araddr_m;
    logic [1:0][ID_W-1:0]       awid_m, arid_m, wid_m;
    logic [1:0][7:0]            awlen_m, arlen_m;
    logic [1:0][2:0]            awsize_m, arsize_m, awprot_m, arprot_m;
    logic [1:0][1:0]            awburst_m, arburst_m;
    logic [1:0][3:0]            awcache_m, arcache_m;
    logic [1:0][DATA_W-1:0]     wdata_m;
    logic [1:0][STRB_W-1:0]     wstrb_m;

    assign awv       = {m1_awvalid, m0_awvalid};
    assign arv       = {m1_arvalid, m0_arvalid};
    assign wv        = {m1_wvalid,  m0_wvalid};
    assign wl        = {m1_wlast,   m0_wlast};
    assign bready_m  = {m1_bready,  m0_bready};
    assign rready_m  = {m1_rready,  m0_rready};
    assign awaddr_m  = {m1_awaddr,  m0_awaddr};
    assign araddr_m  = {m1_araddr,  m0_araddr};
    assign awid_m    = {m1_awid,    m0_awid};
    assign arid_m    = {m1_arid,    m0_arid};
    assign wid_m     = {m1_wid,     m0_wid};
    assign awlen_m   = {m1_awlen,   m0_awlen};
    assign arlen_m   = {m1_arlen,   m0_arlen};
    assign awsize_m  = {m1_awsize,  m0_awsize};
    assign arsize_m  = {m1_arsize,  m0_arsize};
    assign awburst_m = {m1_awburst, m0_awburst};
    assign arburst_m = {m1_arburst, m0_arburst};
    assign awprot_m  = {m1_awprot,  m0_awprot};
    assign arprot_m  = {m1_arprot,  m0_arprot};
    assign awcache_m = {m1_awcache, m0_awcache};
    assign arcache_m = {m1_arcache, m0_arcache};
    assign wdata_m   = {m1_wdata,   m0_wdata};
    assign wstrb_m   = {m1_wstrb,   m0_wstrb};

    axi_arb_rr2 u_rr (
        .req      (awv | arv),
        .last_gnt (last_gnt),
        .en       (state == IDLE),
        .gnt      (gnt)
    );

    // Channel phases; R is only routed once AR has been accepted.
    logic ar_ph, r_ph, aw_ph, w_ph, b_ph;
    assign ar_ph = (state == RD) & ~ar_done;
    assign r_ph  = (state == RD) &  ar_done;
    assign aw_ph = (state == WR_A);
    assign w_ph  = (state == WR_D);
    assign b_ph  = (state == WR_B);

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            ar_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    owner    <= gnt[1];
                    last_gnt <= gnt[1];
                    ar_done  <= 1'b0;
                    state    <= arv[gnt[1]] ? RD : WR_A;
                end
                RD: begin
                    if (s_arvalid & s_arready) ar_done <= 1'b1;
                    if (r_ph & s_rvalid & s_rlast & s_rready) state <= IDLE;
                end
                WR_A:    if (s_awvalid & s_awready)         state <= WR_D;
                WR_D:    if (s_wvalid & s_wready & s_wlast) state <= WR_B;
                WR_B:    if (s_bvalid & s_bready)           state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign s_arvalid = ar_ph & arv[owner];
    assign s_araddr  = ar_ph ? araddr_m[owner]  : '0;
    assign s_arid    = ar_ph ? arid_m[owner]    : '0;
    assign s_arlen   = ar_ph ? arlen_m[owner]   : '0;
    assign s_arsize  = ar_ph ? arsize_m[owner]  : '0;
    assign s_arburst = ar_ph ? arburst_m[owner] : '0;
    assign s_arprot  = ar_ph ? arprot_m[owner]  : '0;
    assign s_arcache = ar_ph ? arcache_m[owner] : '0;
    assign s_awvalid = aw_ph & awv[owner];
    assign s_awaddr  = aw_ph ? awaddr_m[owner]  : '0;
    assign s_awid    = aw_ph ? awid_m[owner]    : '0;
    assign s_awlen   = aw_ph ? awlen_m[owner]   : '0;
    assign s_awsize  = aw_ph ? awsize_m[owner]  : '0;
    assign s_awburst = aw_ph ? awburst_m[owner] : '0;
    assign s_awprot  = aw_ph ? awprot_m[owner]  : '0;
    assign s_awcache = aw_ph ? awcache_m[owner] : '0;
    assign s_wvalid  = w_ph & wv[owner];
    assign s_wdata   = w_ph ? wdata_m[owner] : '0;
    assign s_wstrb   = w_ph ? wstrb_m[owner] : '0;
    assign s_wlast   = w_ph & wl[owner];
    assign s_wid     = w_ph ? wid_m[owner] : '0;
    assign s_bready  = b_ph & bready_m[owner];
    assign s_rready  = r_ph & rready_m[owner];

    logic [1:0]             awready_o, wready_o, arready_o, bvalid_o, rvalid_o, rlast_o;
    logic [1:0][ID_W-1:0]   bid_o, rid_o;
    logic [1:0][1:0]        bresp_o, rresp_o;
    logic [1:0][DATA_W-1:0] rdata_o;

    for (genvar i = 0; i < 2; i++) begin : g_m
        logic sel;
        assign sel          = (owner == 1'(i));
        assign awready_o[i] = aw_ph & sel & s_awready;
        assign wready_o[i]  = w_ph  & sel & s_wready;
        assign arready_o[i] = ar_ph & sel & s_arready;
        assign bvalid_o[i]  = b_ph  & sel & s_bvalid;
        assign bid_o[i]     = (b_ph & sel) ? s_bid   : '0;
        assign bresp_o[i]   = (b_ph & sel) ? s_bresp : '0;
        assign rvalid_o[i]  = r_ph  & sel & s_rvalid;
        assign rlast_o[i]   = r_ph  & sel & s_rlast;
        assign rid_o[i]     = (r_ph & sel) ? s_rid   : '0;
        assign rresp_o[i]   = (r_ph & sel) ? s_rresp : '0;
        assign rdata_o[i]   = (r_ph & sel) ? s_rdata : '0;
    end

    assign {m1_awready, m0_awready} = awready_o;
    assign {m1_wready,  m0_wready}  = wready_o;
    assign {m1_arready, m0_arready} = arready_o;
    assign {m1_bvalid,  m0_bvalid}  = bvalid_o;
    assign {m1_rvalid,  m0_rvalid}  = rvalid_o;
    assign {m1_rlast,   m0_rlast}   = rlast_o;
    assign {m1_bid,     m0_bid}     = bid_o;
    assign {m1_bresp,   m0_bresp}   = bresp_o;
    assign {m1_rid,     m0_rid}     = rid_o;
    assign {m1_rresp,   m0_rresp}   = rresp_o;
    assign {m1_rdata,   m0_rdata}   = rdata_o;
endmodule

// File: tb/tb_axi_slave_arb2.sv
// Directed bench for axi_slave_arb2: slave responses scripted cycle by cycle.
module tb_axi_slave_arb2;
    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    logic         m0_awvalid, m0_awready, m0_wvalid, m0_wlast, m0_wready, m0_bvalid, m0_bready;
    logic         m0_arvalid, m0_arready, m0_rvalid, m0_rlast, m0_rready;
    logic [39:0]  m0_awaddr, m0_araddr;
    logic [7:0]   m0_awid, m0_wid, m0_bid, m0_arid, m0_rid, m0_awlen, m0_arlen;
    logic [2:0]   m0_awsize, m0_arsize, m0_awprot, m0_arprot;
    logic [1:0]   m0_awburst, m0_arburst, m0_bresp, m0_rresp;
    logic [3:0]   m0_awcache, m0_arcache;
    logic [127:0] m0_wdata, m0_rdata;
    logic [15:0]  m0_wstrb;
    logic         m1_awvalid, m1_awready, m1_wvalid, m1_wlast, m1_wready, m1_bvalid, m1_bready;
    logic         m1_arvalid, m1_arready, m1_rvalid, m1_rlast, m1_rready;
    logic [39:0]  m1_awaddr, m1_araddr;
    logic [7:0]   m1_awid, m1_wid, m1_bid, m1_arid, m1_rid, m1_awlen, m1_arlen;
    logic [2:0]   m1_awsize, m1_arsize, m1_awprot, m1_arprot;
    logic [1:0]   m1_awburst, m1_arburst, m1_bresp, m1_rresp;
    logic [3:0]   m1_awcache, m1_arcache;
    logic [127:0] m1_wdata, m1_rdata;
    logic [15:0]  m1_wstrb;
    logic         s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
    logic         s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
    logic [39:0]  s_awaddr, s_araddr;
    logic [7:0]   s_awid, s_wid, s_bid, s_arid, s_rid, s_awlen, s_arlen;
    logic [2:0]   s_awsize, s_arsize, s_awprot, s_arprot;
    logic [1:0]   s_awburst, s_arburst, s_bresp, s_rresp;
    logic [3:0]   s_awcache, s_arcache;
    logic [127:0] s_wdata, s_rdata;
    logic [15:0]  s_wstrb;

    axi_slave_arb2 dut (
        .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_b),
        .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr), .m0_awid(m0_awid), .m0_awlen(m0_awlen),
        .m0_awsize(m0_awsize), .m0_awburst(m0_awburst), .m0_awprot(m0_awprot), .m0_awcache(m0_awcache),
        .m0_awready(m0_awready), .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_wlast(m0_wlast), .m0_wid(m0_wid), .m0_wready(m0_wready), .m0_bvalid(m0_bvalid),
        .m0_bid(m0_bid), .m0_bresp(m0_bresp), .m0_bready(m0_bready), .m0_arvalid(m0_arvalid),
        .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_arprot(m0_arprot), .m0_arcache(m0_arcache), .m0_arready(m0_arready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rid(m0_rid), .m0_rresp(m0_rresp),
        .m0_rlast(m0_rlast), .m0_rready(m0_rready),
        .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
        .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_awprot(m1_awprot), .m1_awcache(m1_awcache),
        .m1_awready(m1_awready), .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_wlast(m1_wlast), .m1_wid(m1_wid), .m1_wready(m1_wready), .m1_bvalid(m1_bvalid),
        .m1_bid(m1_bid), .m1_bresp(m1_bresp), .m1_bready(m1_bready), .m1_arvalid(m1_arvalid),
        .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_arprot(m1_arprot), .m1_arcache(m1_arcache), .m1_arready(m1_arready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rid(m1_rid), .m1_rresp(m1_rresp),
        .m1_rlast(m1_rlast), .m1_rready(m1_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awprot(s_awprot), .s_awcache(s_awcache),
        .s_awready(s_awready), .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_wid(s_wid), .s_wready(s_wready), .s_bvalid(s_bvalid),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bready(s_bready), .s_arvalid(s_arvalid),
        .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arprot(s_arprot), .s_arcache(s_arcache), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rready(s_rready)
    );

    int passed = 0, fails = 0, total = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin fails++; $error("FAIL %s: observed %b expected %b", tag, obs, exp); end
    endtask

    task automatic chkv(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin fails++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end
    endtask

    task automatic nxt; @(posedge clk); #1; endtask

    task automatic set_ar(input int m, input logic v, input logic [39:0] a, input logic [7:0] id, input logic [7:0] len);
        if (m == 0) begin m0_arvalid = v; m0_araddr = a; m0_arid = id; m0_arlen = len; end
        else        begin m1_arvalid = v; m1_araddr = a; m1_arid = id; m1_arlen = len; end
    endtask

    task automatic set_aw(input int m, input logic v, input logic [39:0] a, input logic [7:0] id, input logic [7:0] len);
        if (m == 0) begin m0_awvalid = v; m0_awaddr = a; m0_awid = id; m0_awlen = len; end
        else        begin m1_awvalid = v; m1_awaddr = a; m1_awid = id; m1_awlen = len; end
    endtask

    task automatic set_w(input int m, input logic v, input logic [127:0] d, input logic last, input logic [7:0] id);
        if (m == 0) begin m0_wvalid = v; m0_wdata = d; m0_wlast = last; m0_wid = id; m0_wstrb = 16'hFFFF; end
        else        begin m1_wvalid = v; m1_wdata = d; m1_wlast = last; m1_wid = id; m1_wstrb = 16'hFFFF; end
    endtask

    // Full read from IDLE: grant, AR handshake, len+1 R beats, back to IDLE.
    task automatic do_read(input int m, input logic [39:0] a, input logic [7:0] id, input logic [7:0] len);
        logic [127:0] d;
        set_ar(m, 1'b1, a, id, len);
        #4;
        chk1("rd_idle_arvalid", s_arvalid, 1'b0);
        chk1("rd_idle_awvalid", s_awvalid, 1'b0);
        nxt;
        s_arready = 1'b1;
        #4;
        chk1("rd_s_arvalid", s_arvalid, 1'b1);
        chkv("rd_s_araddr", 128'(s_araddr), 128'(a));
        chkv("rd_s_arid", 128'(s_arid), 128'(id));
        chkv("rd_s_arlen", 128'(s_arlen), 128'(len));
        chk1("rd_own_arready", (m != 0) ? m1_arready : m0_arready, 1'b1);
        chk1("rd_oth_arready", (m != 0) ? m0_arready : m1_arready, 1'b0);
        nxt;
        set_ar(m, 1'b0, '0, '0, '0);
        s_arready = 1'b0; m0_rready = 1'b1; m1_rready = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            d = {a[31:0], 32'(b), 56'h0, id};
            s_rvalid = 1'b1; s_rdata = d; s_rid = id; s_rlast = (b == int'(len));
            #4;
            chk1("r_own_rvalid", (m != 0) ? m1_rvalid : m0_rvalid, 1'b1);
            chkv("r_own_rdata", (m != 0) ? m1_rdata : m0_rdata, d);
            chkv("r_own_rid", 128'((m != 0) ? m1_rid : m0_rid), 128'(id));
            chk1("r_own_rlast", (m != 0) ? m1_rlast : m0_rlast, b == int'(len));
            chk1("r_oth_rvalid", (m != 0) ? m0_rvalid : m1_rvalid, 1'b0);
            chkv("r_oth_rdata", (m != 0) ? m0_rdata : m1_rdata, '0);
            chk1("r_s_rready", s_rready, 1'b1);
            chk1("r_s_awvalid", s_awvalid, 1'b0);
            chk1("r_s_wvalid", s_wvalid, 1'b0);
            chk1("r_m1_wready", m1_wready, 1'b0);
            nxt;
        end
        s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; s_rid = '0;
    endtask

    // Full write from IDLE: grant, AW handshake, len+1 W beats, one B.
    task automatic do_write(input int m, input logic [39:0] a, input logic [7:0] id, input logic [7:0] len);
        logic [127:0] d;
        set_aw(m, 1'b1, a, id, len);
        #4;
        chk1("wr_idle_awvalid", s_awvalid, 1'b0);
        chk1("wr_idle_wvalid", s_wvalid, 1'b0);
        nxt;
        s_awready = 1'b1; s_wready = 1'b1;
        #4;
        chk1("wr_s_awvalid", s_awvalid, 1'b1);
        chkv("wr_s_awaddr", 128'(s_awaddr), 128'(a));
        chkv("wr_s_awid", 128'(s_awid), 128'(id));
        chk1("wr_own_awready", (m != 0) ? m1_awready : m0_awready, 1'b1);
        chk1("wr_oth_awready", (m != 0) ? m0_awready : m1_awready, 1'b0);
        chk1("wr_a_own_wready", (m != 0) ? m1_wready : m0_wready, 1'b0);
        chk1("wr_a_s_wvalid", s_wvalid, 1'b0);
        nxt;
        set_aw(m, 1'b0, '0, '0, '0);
        s_awready = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            d = {32'hDA7A0000 | 32'(b), a[31:0], 56'h0, id};
            set_w(m, 1'b1, d, b == int'(len), id);
            #4;
            chk1("w_s_wvalid", s_wvalid, 1'b1);
            chkv("w_s_wdata", s_wdata, d);
            chk1("w_s_wlast", s_wlast, b == int'(len));
            chk1("w_own_wready", (m != 0) ? m1_wready : m0_wready, 1'b1);
            chk1("w_oth_wready", (m != 0) ? m0_wready : m1_wready, 1'b0);
            nxt;
        end
        set_w(m, 1'b0, '0, 1'b0, '0);
        s_wready = 1'b0;
        s_bvalid = 1'b1; s_bid = id; s_bresp = 2'b00; m0_bready = 1'b1; m1_bready = 1'b1;
        #4;
        chk1("b_own_bvalid", (m != 0) ? m1_bvalid : m0_bvalid, 1'b1);
        chkv("b_own_bid", 128'((m != 0) ? m1_bid : m0_bid), 128'(id));
        chk1("b_oth_bvalid", (m != 0) ? m0_bvalid : m1_bvalid, 1'b0);
        chk1("b_s_bready", s_bready, 1'b1);
        nxt;
        s_bvalid = 1'b0; s_bid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b = 1'b0;
        {m0_awvalid, m0_awaddr, m0_awid, m0_awlen, m0_awsize, m0_awburst, m0_awprot, m0_awcache} = '0;
        {m0_wvalid, m0_wdata, m0_wstrb, m0_wlast, m0_wid, m0_bready, m0_rready} = '0;
        {m0_arvalid, m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst, m0_arprot, m0_arcache} = '0;
        {m1_awvalid, m1_awaddr, m1_awid, m1_awlen, m1_awsize, m1_awburst, m1_awprot, m1_awcache} = '0;
        {m1_wvalid, m1_wdata, m1_wstrb, m1_wlast, m1_wid, m1_bready, m1_rready} = '0;
        {m1_arvalid, m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst, m1_arprot, m1_arcache} = '0;
        {s_awready, s_wready, s_bvalid, s_bid, s_bresp} = '0;
        {s_arready, s_rvalid, s_rdata, s_rid, s_rresp, s_rlast} = '0;

        // Reset held with requests and slave traffic present: everything stays 0.
        set_ar(0, 1'b1, 40'h100, 8'h01, 8'd1);
        set_ar(1, 1'b1, 40'h200, 8'h02, 8'd1);
        s_rvalid = 1'b1; s_rdata = 128'hDEAD; s_bvalid = 1'b1; s_arready = 1'b1;
        nxt; nxt;
        #3;
        chk1("rst_s_arvalid", s_arvalid, 1'b0);
        chkv("rst_s_araddr", 128'(s_araddr), '0);
        chk1("rst_m0_arready", m0_arready, 1'b0);
        chk1("rst_m0_rvalid", m0_rvalid, 1'b0);
        chkv("rst_m0_rdata", m0_rdata, '0);
        chk1("rst_m1_bvalid", m1_bvalid, 1'b0);
        chk1("rst_s_rready", s_rready, 1'b0);
        chk1("rst_s_bready", s_bready, 1'b0);
        nxt;
        s_rvalid = 1'b0; s_rdata = '0; s_bvalid = 1'b0; s_arready = 1'b0;
        rst_b = 1'b1;

        // First tie after reset goes to m0, then m1; second tie alternates back to m0.
        do_read(0, 40'h100, 8'h01, 8'd1);
        do_read(1, 40'h200, 8'h02, 8'd1);
        set_ar(1, 1'b1, 40'h280, 8'h22, 8'd0);
        do_read(0, 40'h180, 8'h21, 8'd0);
        do_read(1, 40'h280, 8'h22, 8'd0);

        // Lone m0 four-beat read.
        do_read(0, 40'h1000, 8'h11, 8'd3);

        // m1 two-beat write with id 0x5A.
        do_write(1, 40'h4000, 8'h5A, 8'd1);

        // m0 with AR and AW together: read first, write in the following IDLE.
        set_aw(0, 1'b1, 40'h5000, 8'h66, 8'd0);
        do_read(0, 40'h5100, 8'h67, 8'd1);
        do_write(0, 40'h5000, 8'h66, 8'd0);

        // m1 W shown early while m0 reads: held off until m1 owns the data phase.
        set_w(1, 1'b1, 128'hBAD0_BAD0, 1'b1, 8'h77);
        do_read(0, 40'h6000, 8'h70, 8'd1);
        do_write(1, 40'h6800, 8'h77, 8'd0);

        // Reset mid write-data burst.
        set_aw(0, 1'b1, 40'h2000, 8'h33, 8'd3);
        nxt;
        s_awready = 1'b1;
        nxt;
        set_aw(0, 1'b0, '0, '0, '0);
        s_awready = 1'b0; s_wready = 1'b1;
        set_w(0, 1'b1, 128'h1111, 1'b0, 8'h33);
        #4;
        chk1("rwd_beat0_wvalid", s_wvalid, 1'b1);
        nxt;
        set_w(0, 1'b1, 128'h2222, 1'b0, 8'h33);
        #1;
        chkv("rwd_beat1_wdata", s_wdata, 128'h2222);
        rst_b = 1'b0;
        s_bvalid = 1'b1; s_bid = 8'h33;
        #1;
        chk1("rwd_s_wvalid", s_wvalid, 1'b0);
        chkv("rwd_s_wdata", s_wdata, '0);
        chk1("rwd_m0_wready", m0_wready, 1'b0);
        chk1("rwd_m0_bvalid", m0_bvalid, 1'b0);
        chkv("rwd_m0_bid", 128'(m0_bid), '0);
        chk1("rwd_s_bready", s_bready, 1'b0);
        nxt; nxt;
        set_w(0, 1'b0, '0, 1'b0, '0);
        s_wready = 1'b0;
        rst_b = 1'b1;
        #4;
        chk1("post_rst_m0_bvalid", m0_bvalid, 1'b0);
        chk1("post_rst_m1_bvalid", m1_bvalid, 1'b0);
        chk1("post_rst_s_bready", s_bready, 1'b0);
        nxt;
        s_bvalid = 1'b0; s_bid = '0;
        do_read(1, 40'h3000, 8'h44, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
